// File: rtl/piece_queue.sv
// piece_queue
//   Sequencer between the random bag generator and the game controller.
//   Requests 7-piece bags, unpacks each 21-bit bag into a FIFO of 3-bit
//   piece codes and serves them one at a time over a valid/take handshake.
//   A new bag is requested whenever at least 7 slots are free, so the head
//   piece does not starve.
//
// Parameters
//   DEPTH    FIFO slots in pieces (7..28)
//   TIMEOUT  max wait cycles for bag_ready after a request (1..65535)
//   PREVIEW  pieces shown on o_preview (1..7, preview build only)
//
// Ports
//   i_clk          system clock, all state on posedge
//   i_nreset       asynchronous active-low reset
//   o_newbag       one-cycle request pulse to the bag generator
//   i_bag_ready    bag generator ready level; bag valid while high
//   i_bag_pieces   7 codes, piece i in [3i+2:3i], piece 0 dealt first
//   i_flush        synchronous queue clear (new game)
//   o_piece_valid  o_piece_out holds a valid piece
//   o_piece_out    registered head piece code
//   i_piece_take   pop the head; ignored while the queue is empty
//   o_level        pieces currently queued
//   o_bag_err      one-cycle pulse: rejected bag or request timeout
//   o_preview      pieces head+1..head+PREVIEW, slot 0 in [2:0], 7 = empty
//
// Configuration
//   PIECE_QUEUE_PREVIEW_EN  when defined, adds the registered o_preview port.

module piece_queue #(
  parameter int DEPTH   = 14,
  parameter int TIMEOUT = 1023,
  parameter int PREVIEW = 3
) (
  input  logic                       i_clk,
  input  logic                       i_nreset,
  output logic                       o_newbag,
  input  logic                       i_bag_ready,
  input  logic [20:0]                i_bag_pieces,
  input  logic                       i_flush,
  output logic                       o_piece_valid,
  output logic [2:0]                 o_piece_out,
  input  logic                       i_piece_take,
  output logic [$clog2(DEPTH+1)-1:0] o_level,
  output logic                       o_bag_err
`ifdef PIECE_QUEUE_PREVIEW_EN
  ,
  output logic [3*PREVIEW-1:0]       o_preview
`endif
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0] REFILL_MAX = LW'(DEPTH - 7);
  localparam logic [15:0]   CNT_LAST   = 16'(TIMEOUT - 1);

  if (DEPTH < 7 || DEPTH > 28 || TIMEOUT < 1 || TIMEOUT > 65535 ||
      PREVIEW < 1 || PREVIEW > 7) begin : g_bad_params
    $error("piece_queue: parameter out of legal range");
  end

  typedef enum logic [2:0] {IDLE, REQ, WLO, WHI, LOAD} state_t;

  state_t          r_state;
  logic [15:0]     r_cnt;
  logic [20:0]     r_bag;
  logic            r_bad;
  logic            r_newbag;
  logic            r_bagErr;
  logic [2:0]      r_mem [DEPTH];
  logic [PW-1:0]   r_rd;
  logic [PW-1:0]   r_wr;
  logic [LW-1:0]   r_level;
  logic            r_valid;
  logic [2:0]      r_head;

  logic            w_pop;
  logic            w_load;
  logic            w_bagBad;
  logic [PW-1:0]   w_rdNext;
  logic [PW-1:0]   w_wrBase;
  logic [PW-1:0]   w_wrNext;
  logic [LW-1:0]   w_lvlBase;
  logic [LW-1:0]   w_levelNext;
  logic [2:0]      w_memNext [DEPTH];

  // Pointer advance modulo DEPTH; offsets never exceed DEPTH so one
  // conditional subtract is enough.
  function automatic logic [PW-1:0] wrapAdd(input logic [PW-1:0] base, input int off);
    logic [PW:0] s;
    s = {1'b0, base} + (PW+1)'(off);
    if (s >= (PW+1)'(DEPTH)) s = s - (PW+1)'(DEPTH);
    return s[PW-1:0];
  endfunction

  // A bag carrying code 7 anywhere is rejected as a whole.
  always_comb begin
    w_bagBad = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i_bag_pieces[3*i +: 3] == 3'd7) w_bagBad = 1'b1;
    end
  end

  // Next FIFO contents: flush clears first, then a same-cycle pop, then the
  // bag write lands on top so a flush during LOAD keeps only the new bag.
  always_comb begin
    w_pop       = r_valid & i_piece_take;
    w_load      = (r_state == LOAD) & ~r_bad;
    w_rdNext    = i_flush ? '0 : (w_pop ? wrapAdd(r_rd, 1) : r_rd);
    w_wrBase    = i_flush ? '0 : r_wr;
    w_lvlBase   = i_flush ? '0 : (r_level - LW'(w_pop));
    w_levelNext = w_lvlBase + (w_load ? LW'(7) : '0);
    w_wrNext    = w_load ? wrapAdd(w_wrBase, 7) : w_wrBase;
    w_memNext   = r_mem;
    if (w_load) begin
      for (int i = 0; i < 7; i++) begin
        w_memNext[wrapAdd(w_wrBase, i)] = r_bag[3*i +: 3];
      end
    end
  end

  // Queue storage, pointers and the registered head view.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
      r_level <= '0;
      r_valid <= 1'b0;
      r_head  <= 3'd0;
    end else begin
      r_mem   <= w_memNext;
      r_rd    <= w_rdNext;
      r_wr    <= w_wrNext;
      r_level <= w_levelNext;
      r_valid <= (w_levelNext != '0);
      r_head  <= (w_levelNext != '0) ? w_memNext[w_rdNext] : 3'd0;
    end
  end

  // Request sequencer. The bag is captured when WHI sees ready, so the
  // accept/reject decision and bag_err are registered into the LOAD cycle;
  // a timeout reuses LOAD as a rejected-bag cycle to get the same pulse.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_bag    <= '0;
      r_bad    <= 1'b0;
      r_newbag <= 1'b0;
      r_bagErr <= 1'b0;
    end else begin
      r_newbag <= 1'b0;
      r_bagErr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_lvlBase <= REFILL_MAX) begin
            r_state  <= REQ;
            r_newbag <= 1'b1;
            r_cnt    <= '0;
          end
        end
        REQ: r_state <= WLO;
        WLO: begin
          if (r_cnt == CNT_LAST) begin
            r_bad    <= 1'b1;
            r_bagErr <= 1'b1;
            r_state  <= LOAD;
          end else begin
            if (!i_bag_ready) r_state <= WHI;
            r_cnt <= r_cnt + 16'd1;
          end
        end
        WHI: begin
          if (i_bag_ready) begin
            r_bag    <= i_bag_pieces;
            r_bad    <= w_bagBad;
            r_bagErr <= w_bagBad;
            r_state  <= LOAD;
          end else if (r_cnt == CNT_LAST) begin
            r_bad    <= 1'b1;
            r_bagErr <= 1'b1;
            r_state  <= LOAD;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        LOAD: begin
          if (r_bad) begin
            r_state  <= REQ;
            r_newbag <= 1'b1;
            r_cnt    <= '0;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef PIECE_QUEUE_PREVIEW_EN
  logic [3*PREVIEW-1:0] r_preview;
  logic [3*PREVIEW-1:0] w_previewNext;

  // Preview follows the same next-state view as the head register.
  always_comb begin
    w_previewNext = '0;
    for (int k = 0; k < PREVIEW; k++) begin
      w_previewNext[3*k +: 3] = (k + 1 < int'(w_levelNext)) ?
                                w_memNext[wrapAdd(w_rdNext, k + 1)] : 3'd7;
    end
  end

  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) r_preview <= '0;
    else           r_preview <= w_previewNext;
  end

  assign o_preview = r_preview;
`endif

  assign o_newbag      = r_newbag;
  assign o_bag_err     = r_bagErr;
  assign o_piece_valid = r_valid;
  assign o_piece_out   = r_head;
  assign o_level       = r_level;

endmodule

// File: tb/tb_piece_queue.sv
module tb_piece_queue;

  localparam int DEPTH   = 14;
  localparam int TIMEOUT = 20;
  localparam int PREVIEW = 3;

  logic        clk = 1'b0;
  logic        nreset;
  logic        newbag;
  logic        ready;
  logic [20:0] pieces;
  logic        flush;
  logic        pieceValid;
  logic [2:0]  pieceOut;
  logic        take;
  logic [3:0]  level;
  logic        bagErr;
`ifdef PIECE_QUEUE_PREVIEW_EN
  logic [3*PREVIEW-1:0] preview;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: queue contents plus the request/wait timeline
  // expressed as "cycles since newbag" and "low seen during the wait".
  int         mq[$];
  bit         mNewbag, mWait, mLoad, mSawLow, mBad;
  int         mW;
  logic [2:0] mBag[7];
  bit         afterReset;

  // Bag generator model: mode 0 random, 1 silent, 2 fixed bag after 5
  // cycles, 3 fixed bag with code 7 in slot 3 after 4 cycles.
  int          bmMode;
  int          bmCount;
  logic [20:0] bmBag;
  logic [20:0] fixedBag;

  always #5 clk = ~clk;

  piece_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .PREVIEW(PREVIEW)) dut (
    .i_clk(clk),
    .i_nreset(nreset),
    .o_newbag(newbag),
    .i_bag_ready(ready),
    .i_bag_pieces(pieces),
    .i_flush(flush),
    .o_piece_valid(pieceValid),
    .o_piece_out(pieceOut),
    .i_piece_take(take),
    .o_level(level),
`ifdef PIECE_QUEUE_PREVIEW_EN
    .o_preview(preview),
`endif
    .o_bag_err(bagErr)
  );

  // Single comparison point; every check in the bench goes through here.
  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Compare all DUT outputs against the model for the current cycle.
  task automatic checkOutput;
    checkVal("valid", 32'(pieceValid), 32'(mq.size() > 0));
    if (mq.size() > 0) checkVal("piece", 32'(pieceOut), 32'(mq[0]));
    checkVal("level", 32'(level), 32'(mq.size()));
    checkVal("newbag", 32'(newbag), 32'(mNewbag));
    checkVal("bagerr", 32'(bagErr), 32'(mLoad && mBad));
`ifdef PIECE_QUEUE_PREVIEW_EN
    begin
      logic [3*PREVIEW-1:0] expPrev;
      expPrev = '0;
      for (int k = 0; k < PREVIEW; k++) begin
        if (!afterReset) expPrev[3*k +: 3] = (k + 1 < mq.size()) ? 3'(mq[k+1]) : 3'd7;
      end
      checkVal("preview", 32'(preview), 32'(expPrev));
    end
`endif
  endtask

  // Drive this cycle's inputs, including the bag generator's response.
  task automatic applyStimulus(input bit tk, input bit fl);
    take  = tk;
    flush = fl;
    if (newbag === 1'b1) begin
      ready = 1'b0;
      case (bmMode)
        1: bmCount = -1;
        2: begin bmCount = 5; bmBag = fixedBag; end
        3: begin bmCount = 4; bmBag = fixedBag; bmBag[11:9] = 3'd7; end
        default: begin
          if ($urandom_range(0, 19) == 0) bmCount = -1;
          else bmCount = $urandom_range(1, 6);
          for (int i = 0; i < 7; i++) bmBag[3*i +: 3] = 3'($urandom_range(0, 6));
          if ($urandom_range(0, 7) == 0) bmBag[3*$urandom_range(0, 6) +: 3] = 3'd7;
        end
      endcase
    end else if (bmCount > 0) begin
      bmCount--;
      if (bmCount == 0) begin
        ready  = 1'b1;
        pieces = bmBag;
      end
    end
  endtask

  // Advance the model by one clock using the inputs just applied.
  task automatic modelStep;
    bit pop     = take && (mq.size() > 0);
    bit idle    = !mNewbag && !mWait && !mLoad;
    bit nNewbag = 0, nWait = 0, nLoad = 0, nSaw = 0, nBad = mBad;
    int nW      = 0;
    if (flush) mq.delete();
    else if (pop) void'(mq.pop_front());
    if (mLoad && !mBad) for (int i = 0; i < 7; i++) mq.push_back(int'(mBag[i]));
    if (mNewbag) begin
      nWait = 1; nW = 1; nSaw = 0;
    end
    if (mWait) begin
      if (ready && mSawLow) begin
        nLoad = 1; nBad = 0;
        for (int i = 0; i < 7; i++) begin
          mBag[i] = pieces[3*i +: 3];
          if (mBag[i] == 3'd7) nBad = 1;
        end
      end else if (mW == TIMEOUT) begin
        nLoad = 1; nBad = 1;
      end else begin
        nWait = 1; nW = mW + 1; nSaw = mSawLow || !ready;
      end
    end
    if (mLoad && mBad) nNewbag = 1;
    if (idle && (DEPTH - mq.size() >= 7)) nNewbag = 1;
    mNewbag = nNewbag; mWait = nWait; mLoad = nLoad;
    mSawLow = nSaw; mBad = nBad; mW = nW;
    afterReset = 0;
  endtask

  task automatic runCycle(input bit tk, input bit fl);
    applyStimulus(tk, fl);
    modelStep();
    @(posedge clk);
    #1;
    cyc++;
    checkOutput();
  endtask

  // Directed phases followed by a long randomized run.
  initial begin
    int nbCyc;
    int errCyc;
    bit seen;
    logic [3:0] lvlAtErr;

    fixedBag = {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    nreset = 1'b0; take = 1'b0; flush = 1'b0; ready = 1'b0; pieces = '0;
    bmMode = 2; bmCount = 0; bmBag = '0;
    mNewbag = 0; mWait = 0; mLoad = 0; mSawLow = 0; mBad = 0; mW = 0;
    afterReset = 1;
    repeat (3) @(posedge clk);
    #1;
    checkVal("rst-valid", 32'(pieceValid), 0);
    checkVal("rst-piece", 32'(pieceOut), 0);
    checkVal("rst-level", 32'(level), 0);
    checkVal("rst-newbag", 32'(newbag), 0);
    checkVal("rst-bagerr", 32'(bagErr), 0);
    nreset = 1'b1;
    checkOutput();

    $display("[TB] phase A: first two bags");
    repeat (25) runCycle(1'b0, 1'b0);
    checkVal("fill-level", 32'(level), 14);
    checkVal("fill-head", 32'(pieceOut), 0);

    $display("[TB] phase B: back-to-back pops");
    for (int i = 0; i < 14; i++) begin
      checkVal("pop-valid", 32'(pieceValid), 1);
      checkVal("pop-order", 32'(pieceOut), 32'(i % 7));
      runCycle(1'b1, 1'b0);
    end

    $display("[TB] phase C: rejected bag");
    bmMode = 3;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      runCycle(1'($urandom_range(0, 1)), 1'b0);
      if (newbag) seen = 1;
    end
    checkVal("c-newbag-seen", 32'(seen), 1);
    nbCyc = cyc;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      runCycle(1'b0, 1'b0);
      if (bagErr) seen = 1;
    end
    checkVal("c-bagerr-seen", 32'(seen), 1);
    checkVal("c-bagerr-delay", 32'(cyc - nbCyc), 5);
    lvlAtErr = level;
    bmMode = 0;
    runCycle(1'b0, 1'b0);
    checkVal("c-retry-newbag", 32'(newbag), 1);
    checkVal("c-level-kept", 32'(level), 32'(lvlAtErr));

    $display("[TB] phase D: request timeout");
    bmMode = 1;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      runCycle(1'($urandom_range(0, 1)), 1'b0);
      if (newbag) seen = 1;
    end
    checkVal("d-newbag-seen", 32'(seen), 1);
    nbCyc = cyc;
    seen = 0;
    for (int i = 0; i < TIMEOUT + 10 && !seen; i++) begin
      runCycle(1'($urandom_range(0, 1)), 1'b0);
      if (bagErr) seen = 1;
    end
    errCyc = cyc;
    checkVal("d-bagerr-seen", 32'(seen), 1);
    checkVal("d-timeout-gap", 32'(errCyc - nbCyc), 32'(TIMEOUT + 1));
    bmMode = 0;
    runCycle(1'b0, 1'b0);
    checkVal("d-retry-newbag", 32'(newbag), 1);

    $display("[TB] phase E: random traffic with flushes");
    for (int i = 0; i < 3000; i++) begin
      runCycle(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 39) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
